// File: rtl/dmem_port_arbiter.sv
// Shares one memory port between the IFU and LSU, one transaction in flight at a time.
// Define DMEM_ARB_RR_EN for round-robin grant on ties; otherwise LSU has fixed priority.
//
// state  | meaning
// S_IDLE | no transaction; combinational grant to a waiting requester
// S_REQ  | mem_req_valid held from latched request until mem_req_ready
// S_WAIT | waiting for mem_resp_valid or timeout
// S_RESP | one-cycle response strobe to the owning requester
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic              ifu_resp_err,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [2:0]        lsu_wlen,
    output logic              lsu_resp_valid,
    output logic              lsu_resp_err,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_wlen,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = LSU owns the transaction
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        wlen_q, wlen_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic grant_any, grant_lsu, accept;

    assign grant_any = ifu_req_valid | lsu_req_valid;
    assign accept    = rst & (state_q == S_IDLE) & grant_any;

`ifdef DMEM_ARB_RR_EN
    logic last_lsu_q, last_lsu_d;

    // On a tie the requester that did not win last time goes next.
    assign grant_lsu  = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);
    assign last_lsu_d = accept ? grant_lsu : last_lsu_q;

    always_ff @(posedge clk) begin
        if (!rst) last_lsu_q <= 1'b0;
        else      last_lsu_q <= last_lsu_d;
    end
`else
    assign grant_lsu = lsu_req_valid;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wlen_d  = wlen_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d = grant_lsu;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                    if (grant_lsu) begin
                        wen_d   = lsu_wen;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        wlen_d  = lsu_wlen;
                    end else begin
                        wen_d   = 1'b0;
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                        wlen_d  = 3'b000;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;   // saturates when timeout is disabled
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wlen_q  <= 3'b000;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wlen_q  <= wlen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifu_req_ready  = accept & ~grant_lsu;
    assign lsu_req_ready  = accept & grant_lsu;

    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wlen       = wlen_q;

    assign ifu_resp_valid = (state_q == S_RESP) & ~owner_q;
    assign lsu_resp_valid = (state_q == S_RESP) & owner_q;
    assign ifu_resp_err   = ifu_resp_valid & err_q;
    assign lsu_resp_err   = lsu_resp_valid & err_q;
    assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
    assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;

    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: timeline-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic          ifu_resp_err;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic          lsu_wen = 1'b0;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [2:0]    lsu_wlen = 3'b000;
    logic          lsu_resp_valid;
    logic          lsu_resp_err;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_wlen;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wlen(lsu_wlen),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: one transaction described by the cycle it was accepted, the cycle memory
    // took the request, and the cycle its response is due.
    int            cyc = 0;
    bit            m_txn = 1'b0;
    int            t_acc = -1, t_hs = -1, t_resp = -1;
    bit            m_lsu, m_wen, m_err, last_lsu = 1'b0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [2:0]    m_wlen;
    logic          rst_at_edge = 1'b1;

    always @(posedge clk) rst_at_edge <= rst;

    bit g_any, g_lsu, e_ready_ifu, e_ready_lsu, e_mreq, e_resp;

    always @(negedge clk) begin
        g_any = ifu_req_valid || lsu_req_valid;
`ifdef DMEM_ARB_RR_EN
        g_lsu = lsu_req_valid && !(ifu_req_valid && last_lsu);
`else
        g_lsu = lsu_req_valid;
`endif
        if (!rst_at_edge) begin
            chk("rst_mem_addr",  mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wen",   mem_wen, 0);
            chk("rst_mem_wlen",  mem_wlen, 0);
            chk("rst_ifu_rdata", ifu_rdata, 0);
            chk("rst_lsu_rdata", lsu_rdata, 0);
            chk("rst_ifu_err",   ifu_resp_err, 0);
            chk("rst_lsu_err",   lsu_resp_err, 0);
        end
        e_ready_ifu = rst && !m_txn && g_any && !g_lsu;
        e_ready_lsu = rst && !m_txn && g_any && g_lsu;
        e_mreq      = m_txn && (t_hs < 0);
        e_resp      = m_txn && (cyc == t_resp);
        chk("m_busy",       busy, m_txn);
        chk("m_ifu_ready",  ifu_req_ready, e_ready_ifu);
        chk("m_lsu_ready",  lsu_req_ready, e_ready_lsu);
        chk("m_mem_req",    mem_req_valid, e_mreq);
        chk("m_ifu_rvalid", ifu_resp_valid, e_resp && !m_lsu);
        chk("m_lsu_rvalid", lsu_resp_valid, e_resp && m_lsu);
        if (e_mreq) begin
            chk("m_mem_addr",  mem_addr, m_addr);
            chk("m_mem_wen",   mem_wen, m_wen);
            chk("m_mem_wdata", mem_wdata, m_wdata);
            chk("m_mem_wlen",  mem_wlen, m_wlen);
        end
        if (e_resp && m_lsu) begin
            chk("m_lsu_rdata", lsu_rdata, m_rdata);
            chk("m_lsu_err",   lsu_resp_err, m_err);
        end
        if (e_resp && !m_lsu) begin
            chk("m_ifu_rdata", ifu_rdata, m_rdata);
            chk("m_ifu_err",   ifu_resp_err, m_err);
        end

        if (!rst) begin
            m_txn    = 1'b0;
            last_lsu = 1'b0;
        end else if (!m_txn) begin
            if (g_any) begin
                m_txn    = 1'b1;
                m_lsu    = g_lsu;
                last_lsu = g_lsu;
                t_acc    = cyc;
                t_hs     = -1;
                t_resp   = -1;
                m_addr   = g_lsu ? lsu_addr : ifu_addr;
                m_wen    = g_lsu ? lsu_wen : 1'b0;
                m_wdata  = g_lsu ? lsu_wdata : '0;
                m_wlen   = g_lsu ? lsu_wlen : 3'b000;
            end
        end else if (t_hs < 0) begin
            if (mem_req_ready) t_hs = cyc;
        end else if (t_resp < 0) begin
            if (mem_resp_valid) begin
                t_resp  = cyc + 1;
                m_rdata = m_wen ? '0 : mem_rdata;
                m_err   = 1'b0;
            end else if (TO != 0 && (cyc - t_hs) == TO) begin
                t_resp  = cyc + 1;
                m_rdata = '0;
                m_err   = 1'b1;
            end
        end else if (cyc == t_resp) begin
            m_txn = 1'b0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        chk("idle_bound", (k < 50), 1);
    endtask

    int lsu_cnt, ifu_cnt, first_lsu, k;

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        rst = 1'b1;
        tick();

        // IFU read, minimum latency
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        chk("t1_ifu_ready", ifu_req_ready, 1);
        chk("t1_lsu_ready", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t1_mem_req", mem_req_valid, 1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        #1;
        chk("t1_resp_valid", ifu_resp_valid, 1);
        chk("t1_rdata", ifu_rdata, 32'h1234_5678);
        chk("t1_err", ifu_resp_err, 0);
        tick();
        chk("t1_one_cycle", ifu_resp_valid, 0);
        chk("t1_idle", busy, 0);

        // LSU byte store, memory slow to accept
        mem_req_ready = 1'b0;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0010;
        lsu_wdata = 32'h0000_00AB; lsu_wlen = 3'b001;
        #1;
        chk("t2_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wlen = 3'b000;
        for (int i = 0; i < 3; i++) begin
            chk("t2_mem_req", mem_req_valid, 1);
            chk("t2_mem_wen", mem_wen, 1);
            chk("t2_mem_wlen", mem_wlen, 3'b001);
            chk("t2_mem_wdata", mem_wdata, 32'h0000_00AB);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        chk("t2_resp_valid", lsu_resp_valid, 1);
        chk("t2_rdata", lsu_rdata, 0);
        chk("t2_ifu_quiet", ifu_resp_valid, 0);
        wait_idle();

        // Both requesting continuously, memory answers immediately
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        lsu_cnt = 0; ifu_cnt = 0; first_lsu = -1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (lsu_req_ready) lsu_cnt++;
            if (ifu_req_ready) ifu_cnt++;
            if (first_lsu < 0 && (lsu_req_ready || ifu_req_ready)) first_lsu = lsu_req_ready ? 1 : 0;
            tick();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
`ifdef DMEM_ARB_RR_EN
        chk("t3_lsu_grants", lsu_cnt, 2);
        chk("t3_ifu_grants", ifu_cnt, 2);
        chk("t3_first_grant", first_lsu, 0);
`else
        chk("t3_lsu_grants", lsu_cnt, 4);
        chk("t3_ifu_grants", ifu_cnt, 0);
        chk("t3_first_grant", first_lsu, 1);
`endif
        wait_idle();
        mem_resp_valid = 1'b0; mem_rdata = '0;

        // LSU load with no memory response: timeout
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0020;
        #1;
        chk("t4_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        k = 1;
        while (!lsu_resp_valid && k < 40) begin
            tick();
            k++;
        end
        chk("t4_latency", k, 10);
        chk("t4_err", lsu_resp_err, 1);
        chk("t4_rdata", lsu_rdata, 0);
        tick();
        chk("t4_idle", busy, 0);

        // Reset while in WAIT, stale response afterwards
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            chk("t5_busy", busy, 0);
            tick();
        end
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0044;
        #1;
        chk("t5_ifu_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        chk("t5_resp_valid", ifu_resp_valid, 1);
        chk("t5_rdata", ifu_rdata, 32'h55AA_55AA);
        tick();

        // Stray responses in IDLE and REQ are ignored
        mem_req_ready = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        ifu_req_valid = 1'b0; mem_rdata = 32'h2222_2222;
        chk("t6_still_req", mem_req_valid, 1);
        tick();
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        chk("t6_no_resp", ifu_resp_valid, 0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0123;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        chk("t6_resp_valid", ifu_resp_valid, 1);
        chk("t6_rdata", ifu_rdata, 32'hCAFE_0123);
        chk("t6_err", ifu_resp_err, 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
